// File: rtl/inst_fetch_queue_pkg.sv
// Shared sizing constants and entry type for the dual-issue instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int IFQ_DEPTH = 8;
  localparam int IFQ_PTR_W = 3;
  localparam logic [31:0] IFQ_PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  // Number of lanes in a two-lane group; lane 2 only counts when lane 1 does.
  function automatic logic [1:0] pair_count(input logic lane_1, input logic lane_2);
    logic [1:0] n;
    if (lane_1 && lane_2) begin
      n = 2'd2;
    end else if (lane_1) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between the ICache read port and decode.
// Two write ports at tail/tail+1, two read ports at head/head+1; count disambiguates full/empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int PTR_W = IFQ_PTR_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic [31:0]      in_inst_1,
  input  logic [31:0]      in_inst_2,
  input  logic [31:0]      in_pc,
  output logic             fq_full,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic [31:0]      out_inst_1,
  output logic [31:0]      out_inst_2,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_pc_2,
  input  logic             dec_pop_1,
  input  logic             dec_pop_2,
  output logic [PTR_W:0]   fq_count,
  output logic             fq_overflow
);

  localparam int CW = PTR_W + 1;
  localparam int SW = PTR_W + 2;
  localparam logic [CW-1:0] FULL_THRESH = CW'(DEPTH - 2);
  localparam logic [SW-1:0] DEPTH_S     = SW'(DEPTH);

  ifq_entry_t         mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CW-1:0]      count_r;
  logic               overflow_r;

  logic [1:0]         np_s;
  logic [1:0]         nq_s;
  logic [1:0]         np_acc_s;
  logic [SW-1:0]      space_s;
  logic               drop_s;
  logic               push_ok_s;
  logic [PTR_W-1:0]   head_p1_s;
  logic [PTR_W-1:0]   tail_p1_s;
  logic               valid_1_s;
  logic               valid_2_s;

  assign valid_1_s = (count_r >= CW'(1));
  assign valid_2_s = (count_r >= CW'(2));
  assign head_p1_s = head_r + PTR_W'(1);
  assign tail_p1_s = tail_r + PTR_W'(1);

  // Push/pop accounting; space is measured after this cycle's pop so a full queue can push while draining.
  always_comb begin
    np_s      = pair_count(in_valid_1, in_valid_2);
    nq_s      = pair_count(dec_pop_1 && valid_1_s, dec_pop_2 && valid_2_s);
    space_s   = DEPTH_S - SW'(count_r) + SW'(nq_s);
    drop_s    = 1'b0;
    push_ok_s = 1'b0;
    np_acc_s  = 2'd0;
    if (SW'(np_s) > space_s) begin
      drop_s = 1'b1;
    end else if (np_s != 2'd0) begin
      push_ok_s = 1'b1;
      np_acc_s  = np_s;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(nq_s);
      tail_r  <= tail_r + PTR_W'(np_acc_s);
      count_r <= count_r - CW'(nq_s) + CW'(np_acc_s);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage; slot 2 lands one past slot 1 with the sequential PC.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push_ok_s) begin
      mem_r[tail_r] <= '{pc: in_pc, inst: in_inst_1};
      if (np_acc_s == 2'd2) begin
        mem_r[tail_p1_s] <= '{pc: in_pc + IFQ_PC_STEP, inst: in_inst_2};
      end
    end
  end

  // Read ports; empty slots drive zero.
  always_comb begin
    out_valid_1 = valid_1_s;
    out_valid_2 = valid_2_s;
    out_inst_1  = 32'd0;
    out_pc_1    = 32'd0;
    out_inst_2  = 32'd0;
    out_pc_2    = 32'd0;
    if (valid_1_s) begin
      out_inst_1 = mem_r[head_r].inst;
      out_pc_1   = mem_r[head_r].pc;
    end else begin
      out_inst_1 = 32'd0;
      out_pc_1   = 32'd0;
    end
    if (valid_2_s) begin
      out_inst_2 = mem_r[head_p1_s].inst;
      out_pc_2   = mem_r[head_p1_s].pc;
    end else begin
      out_inst_2 = 32'd0;
      out_pc_2   = 32'd0;
    end
  end

  assign fq_full     = (count_r > FULL_THRESH);
  assign fq_count    = count_r;
  assign fq_overflow = overflow_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus random stimulus for inst_fetch_queue, checked against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_inst_1, in_inst_2, in_pc;
  logic        fq_full, out_valid_1, out_valid_2;
  logic [31:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
  logic        dec_pop_1, dec_pop_2;
  logic [3:0]  fq_count;
  logic        fq_overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  logic m_ovf;

  inst_fetch_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_inst_1(in_inst_1), .in_inst_2(in_inst_2), .in_pc(in_pc),
    .fq_full(fq_full), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
    .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
    .dec_pop_1(dec_pop_1), .dec_pop_2(dec_pop_2),
    .fq_count(fq_count), .fq_overflow(fq_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(fq_count), 32'(sz));
    chk({tag, ".full"}, 32'(fq_full), 32'(sz > DEPTH - 2));
    chk({tag, ".ovf"}, 32'(fq_overflow), 32'(m_ovf));
    chk({tag, ".v1"}, 32'(out_valid_1), 32'(sz >= 1));
    chk({tag, ".v2"}, 32'(out_valid_2), 32'(sz >= 2));
    chk({tag, ".inst1"}, out_inst_1, (sz >= 1) ? mq[0].inst : 32'd0);
    chk({tag, ".pc1"}, out_pc_1, (sz >= 1) ? mq[0].pc : 32'd0);
    chk({tag, ".inst2"}, out_inst_2, (sz >= 2) ? mq[1].inst : 32'd0);
    chk({tag, ".pc2"}, out_pc_2, (sz >= 2) ? mq[1].pc : 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; flush = 1'b0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0; dec_pop_1 = 1'b0; dec_pop_2 = 1'b0;
    in_inst_1 = 32'd0; in_inst_2 = 32'd0; in_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    check_all("reset");
  endtask

  // One clock: drive inputs, advance the model from its own rules, compare after the edge.
  task automatic step(input string tag, input logic v1, input logic v2, input logic p1,
                      input logic p2, input logic fl, input logic [31:0] i1,
                      input logic [31:0] i2, input logic [31:0] pc);
    int np, nq, sz;
    in_valid_1 = v1; in_valid_2 = v2; dec_pop_1 = p1; dec_pop_2 = p2; flush = fl;
    in_inst_1 = i1; in_inst_2 = i2; in_pc = pc;
    sz = mq.size();
    np = v1 ? (v2 ? 2 : 1) : 0;
    nq = (p1 && sz >= 1) ? ((p2 && sz >= 2) ? 2 : 1) : 0;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      for (int k = 0; k < nq; k++) void'(mq.pop_front());
      if (np > DEPTH - sz + nq) begin
        m_ovf = 1'b1;
      end else begin
        if (np >= 1) mq.push_back('{pc: pc, inst: i1});
        if (np == 2) mq.push_back('{pc: pc + 32'd4, inst: i2});
      end
    end
    in_valid_1 = 1'b0; in_valid_2 = 1'b0; dec_pop_1 = 1'b0; dec_pop_2 = 1'b0; flush = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] r_pc, r_i1, r_i2, rnd;

    do_reset();
    chk("reset.count_const", 32'(fq_count), 32'd0);

    // Dual push becomes visible the following cycle.
    step("t1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_1000);
    chk("t1.pc1_const", out_pc_1, 32'h0000_1000);
    chk("t1.pc2_const", out_pc_2, 32'h0000_1004);
    chk("t1.cnt_const", 32'(fq_count), 32'd2);
    chk("t1.v2_const", 32'(out_valid_2), 32'd1);

    // Single pushes up to 7 entries.
    do_reset();
    for (int k = 0; k < 3; k++)
      step("t2a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000 + 32'(k), 32'd0, 32'h2000 + 32'(k * 4));
    chk("t2.cnt3", 32'(fq_count), 32'd3);
    chk("t2.notfull", 32'(fq_full), 32'd0);
    for (int k = 3; k < 7; k++)
      step("t2b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000 + 32'(k), 32'd0, 32'h2000 + 32'(k * 4));
    chk("t2.full7", 32'(fq_full), 32'd1);

    // Full queue: push 2 while popping 2 is accepted.
    step("t3fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0007, 32'd0, 32'h201C);
    chk("t3.cnt8", 32'(fq_count), 32'd8);
    step("t3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h3000_0001, 32'h4000);
    chk("t3.cnt8b", 32'(fq_count), 32'd8);
    chk("t3.noovf", 32'(fq_overflow), 32'd0);

    // At 7 entries a dual push is dropped whole and overflow sticks.
    step("t4pop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step("t4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 32'h5000);
    chk("t4.cnt7", 32'(fq_count), 32'd7);
    chk("t4.ovf", 32'(fq_overflow), 32'd1);

    // Flush beats a same-cycle push and pop; overflow survives.
    step("t5pop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("t5.cnt5", 32'(fq_count), 32'd5);
    step("t5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hEEEE_0000, 32'hEEEE_0001, 32'h6000);
    chk("t5.cnt0", 32'(fq_count), 32'd0);
    chk("t5.v1", 32'(out_valid_1), 32'd0);
    chk("t5.ovf_kept", 32'(fq_overflow), 32'd1);
    step("t5post", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7777_0000, 32'd0, 32'h7000);
    chk("t5.pc_after", out_pc_1, 32'h0000_7000);

    // Full wrap: DEPTH pushes then DEPTH pops, then refill across index 0.
    do_reset();
    for (int k = 0; k < DEPTH / 2; k++)
      step("wrap_push", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5000_0000 + 32'(k), 32'h5100_0000 + 32'(k), 32'h8000 + 32'(k * 8));
    for (int k = 0; k < DEPTH / 2; k++)
      step("wrap_pop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    step("wrap_again", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h6000_0000, 32'h6000_0001, 32'h9000);

    // Random mixed traffic against the model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rnd  = $urandom;
      r_i1 = $urandom;
      r_i2 = $urandom;
      r_pc = $urandom & 32'hFFFF_FFFC;
      step("rand", rnd[0], rnd[1] | rnd[2], rnd[3], rnd[4] | rnd[5],
           (rnd[13:8] == 6'd0), r_i1, r_i2, r_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
